interboard_tx_arbiter: RTL and testbench

Shares the single inter-board transmit channel among the game-control message handlers (win announcement, move/draw, card placement, …). Each handler fires a one-cycle `*_ctrl_en` pulse with its message fields; the arbiter captures it in a per-requester slot. It then issues slots one at a time to the inter-board sender, pacing on `inter_ready`, and reports per-requester completion. The block sits between the game-control handlers and the inter-board sender.

---
 rtl/interboard_tx_arbiter_pkg.sv | 57 +++++
 rtl/interboard_tx_arbiter_if.sv | 53 +++++
 rtl/interboard_tx_arbiter_arb_pick.sv | 52 +++++
 rtl/interboard_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_interboard_tx_arbiter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/interboard_tx_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// interboard_tx_arbiter_pkg
// Shared constants for the inter-board transmit arbiter: packet width and field
// layout, FSM state encodings, the WAIT_BUSY timeout and a packet builder.
// Configuration macro used elsewhere in this slice: ARB_ROUND_ROBIN_EN.
// -----------------------------------------------------------------------------
package interboard_tx_arbiter_pkg;

  localparam int PKT_W = 22;

  // Field offsets (LSB of each field), MSB->LSB packing.
  localparam int MOVE_DIR_LSB = 21;
  localparam int MSG_TYPE_LSB = 17;
  localparam int CARD_LSB     = 11;
  localparam int SEL_LEN_LSB  = 8;
  localparam int BLOCK_X_LSB  = 3;
  localparam int BLOCK_Y_LSB  = 0;

  typedef struct packed {
    logic       move_dir;
    logic [3:0] msg_type;
    logic [5:0] card;
    logic [2:0] sel_len;
    logic [4:0] block_x;
    logic [2:0] block_y;
  } pkt_t;

  // FSM state encodings.
  localparam int ST_W = 2;
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  // Cycles the sender may keep inter_ready high after an issue strobe before
  // the arbiter assumes the message was taken anyway.
  localparam int BUSY_TIMEOUT = 4;

  function automatic logic [PKT_W-1:0] make_pkt(
    input logic       move_dir,
    input logic [3:0] msg_type,
    input logic [5:0] card,
    input logic [2:0] sel_len,
    input logic [4:0] block_x,
    input logic [2:0] block_y
  );
    pkt_t p;
    p.move_dir = move_dir;
    p.msg_type = msg_type;
    p.card     = card;
    p.sel_len  = sel_len;
    p.block_x  = block_x;
    p.block_y  = block_y;
    return p;
  endfunction

endpackage

// File: rtl/interboard_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// interboard_tx_arbiter_if
// Bundles the requester side and the sender side of the arbiter.
//   req_en / req_pkt   : per-requester one-cycle request pulse and packet
//   inter_ready        : sender idle and able to accept
//   ctrl_en, ctrl_*    : issue strobe and packet fields to the sender
//   req_done           : per-requester one-cycle completion pulse
//   req_pending        : per-requester slot occupied
//   overflow           : sticky, a request hit an occupied slot
//   dbg_state          : current arbiter FSM state
// Modports: slave = arbiter, master = handlers plus sender environment.
//
// Handshake: a request is a single-cycle req_en[i] pulse with no back-pressure;
// it is captured if slot i is empty (or freed in that same cycle), otherwise it
// is dropped and overflow is raised. Toward the sender, ctrl_en is a one-cycle
// strobe sent only while inter_ready=1; the sender acknowledges by dropping
// inter_ready and signals completion by raising it again.
// -----------------------------------------------------------------------------
interface interboard_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import interboard_tx_arbiter_pkg::*;

  logic [NUM_REQ-1:0]       req_en;
  logic [NUM_REQ*PKT_W-1:0] req_pkt;
  logic                     inter_ready;
  logic                     ctrl_en;
  logic                     ctrl_move_dir;
  logic [3:0]               ctrl_msg_type;
  logic [5:0]               ctrl_card;
  logic [2:0]               ctrl_sel_len;
  logic [4:0]               ctrl_block_x;
  logic [2:0]               ctrl_block_y;
  logic [NUM_REQ-1:0]       req_done;
  logic [NUM_REQ-1:0]       req_pending;
  logic                     overflow;
  logic [ST_W-1:0]          dbg_state;

  modport slave (
    input  req_en, req_pkt, inter_ready,
    output ctrl_en, ctrl_move_dir, ctrl_msg_type, ctrl_card, ctrl_sel_len,
           ctrl_block_x, ctrl_block_y, req_done, req_pending, overflow,
           dbg_state
  );

  modport master (
    output req_en, req_pkt, inter_ready,
    input  ctrl_en, ctrl_move_dir, ctrl_msg_type, ctrl_card, ctrl_sel_len,
           ctrl_block_x, ctrl_block_y, req_done, req_pending, overflow,
           dbg_state
  );

endinterface

// File: rtl/interboard_tx_arbiter_arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Combinational grant selection over the slot valid bits.
//   valid_i      : slot occupied bits
//   last_grant_i : most recent grant (used only by the round-robin policy)
//   grant_o      : chosen requester index
//   any_o        : at least one slot is valid
// ARB_ROUND_ROBIN_EN defined: search starts at (last_grant+1) mod NUM_REQ.
// Otherwise: fixed priority, lowest index wins.
// -----------------------------------------------------------------------------
module arb_pick #(
  parameter int NUM_REQ = 4,
  parameter int GW      = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [GW-1:0]      last_grant_i,
  output logic [GW-1:0]      grant_o,
  output logic               any_o
);
  import interboard_tx_arbiter_pkg::*;

  assign any_o = |valid_i;

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    logic          found;
    logic [GW-1:0] idx;
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = GW'((int'(last_grant_i) + k) % NUM_REQ);
      if (!found && valid_i[idx]) begin
        grant_o = idx;
        found   = 1'b1;
      end
    end
  end
`else
  logic unused_last;
  assign unused_last = ^last_grant_i;

  // Scan from the top so the lowest valid index is the last to write.
  always_comb begin
    grant_o = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (valid_i[i]) grant_o = GW'(i);
    end
  end
`endif

endmodule

// File: rtl/interboard_tx_arbiter.sv
// -----------------------------------------------------------------------------
// interboard_tx_arbiter
// Shares the single inter-board transmit channel among game-control message
// handlers. Each requester owns a one-deep slot; slots are issued one at a
// time to the inter-board sender, paced on inter_ready.
// Ports:
//   clk            : system clock
//   rst            : synchronous active-high reset
//   interboard_rst : synchronous active-high reset, same effect as rst
//   bus            : interboard_tx_arbiter_if.slave (requests, sender, status)
// Configuration: define ARB_ROUND_ROBIN_EN for round-robin grant; default is
// fixed priority (lowest index wins) with no last-grant register.
// -----------------------------------------------------------------------------
module interboard_tx_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   interboard_rst,
  interboard_tx_arbiter_if.slave bus
);
  import interboard_tx_arbiter_pkg::*;

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic clr;
  assign clr = rst | interboard_rst;

  logic [NUM_REQ-1:0] valid_q, valid_d;
  logic [PKT_W-1:0]   pkt_q [NUM_REQ];
  logic [PKT_W-1:0]   pkt_d [NUM_REQ];
  logic [ST_W-1:0]    state_q, state_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               ovf_q, ovf_d;
  logic               done_fire;

  logic [GW-1:0]      pick_grant;
  logic [GW-1:0]      last_grant;
  logic               pick_any;

  arb_pick #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_pick (
    .valid_i      (valid_q),
    .last_grant_i (last_grant),
    .grant_o      (pick_grant),
    .any_o        (pick_any)
  );

`ifdef ARB_ROUND_ROBIN_EN
  // Resets to NUM_REQ-1 so the very first search begins at requester 0.
  logic [GW-1:0] last_grant_q;
  always_ff @(posedge clk) begin
    if (clr) begin
      last_grant_q <= GW'(NUM_REQ - 1);
    end else if (state_q == ST_IDLE && state_d == ST_ISSUE) begin
      last_grant_q <= pick_grant;
    end
  end
  assign last_grant = last_grant_q;
`else
  assign last_grant = GW'(NUM_REQ - 1);
`endif

  // Transfer FSM. Grant is only evaluated in IDLE.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    done_fire = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any && bus.inter_ready) begin
          grant_d = pick_grant;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // A sender that never drops ready is assumed to have taken the
        // message after BUSY_TIMEOUT cycles here.
        if (!bus.inter_ready || cnt_q == 3'(BUSY_TIMEOUT - 1)) begin
          state_d = ST_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_WAIT_DONE: begin
        if (bus.inter_ready) begin
          done_fire = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Slot capture / release. A slot released this cycle may take a new packet
  // in the same cycle without raising overflow.
  always_comb begin
    valid_d = valid_q;
    pkt_d   = pkt_q;
    ovf_d   = ovf_q;
    done_d  = '0;
    if (done_fire) done_d[grant_q] = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      logic free_i;
      free_i = done_fire && (grant_q == GW'(i));
      if (free_i) valid_d[i] = 1'b0;
      if (bus.req_en[i]) begin
        if (!valid_q[i] || free_i) begin
          valid_d[i] = 1'b1;
          pkt_d[i]   = bus.req_pkt[i*PKT_W +: PKT_W];
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      cnt_q   <= '0;
      valid_q <= '0;
      done_q  <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) pkt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      pkt_q   <= pkt_d;
    end
  end

  // Fields follow the granted slot from ISSUE through WAIT_DONE, zero in IDLE.
  pkt_t cur;
  assign cur = (state_q != ST_IDLE) ? pkt_t'(pkt_q[grant_q]) : pkt_t'('0);

  assign bus.ctrl_en       = (state_q == ST_ISSUE);
  assign bus.ctrl_move_dir = cur.move_dir;
  assign bus.ctrl_msg_type = cur.msg_type;
  assign bus.ctrl_card     = cur.card;
  assign bus.ctrl_sel_len  = cur.sel_len;
  assign bus.ctrl_block_x  = cur.block_x;
  assign bus.ctrl_block_y  = cur.block_y;
  assign bus.req_done      = done_q;
  assign bus.req_pending   = valid_q;
  assign bus.overflow      = ovf_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_interboard_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_interboard_tx_arbiter
// Directed bench for interboard_tx_arbiter: single request, simultaneous
// requests, overflow, busy timeout, reset mid-transfer and back-to-back reuse.
// -----------------------------------------------------------------------------
module tb_interboard_tx_arbiter;
  import interboard_tx_arbiter_pkg::*;

  localparam int NUM_REQ = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic interboard_rst = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  interboard_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  interboard_tx_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk            (clk),
    .rst            (rst),
    .interboard_rst (interboard_rst),
    .bus            (bus)
  );

  // ---------------- scoreboard ----------------
  logic [PKT_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int issue_cyc = 0;
  int issue_cyc_prev = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic send(input int idx, input logic [PKT_W-1:0] pkt);
    bus.req_en[idx] = 1'b1;
    bus.req_pkt[idx*PKT_W +: PKT_W] = pkt;
  endtask

  task automatic clear_req();
    bus.req_en = '0;
  endtask

  function automatic logic [PKT_W-1:0] out_pkt();
    return {bus.ctrl_move_dir, bus.ctrl_msg_type, bus.ctrl_card,
            bus.ctrl_sel_len, bus.ctrl_block_x, bus.ctrl_block_y};
  endfunction

  // Wait (bounded) for ctrl_en, then compare fields with the scoreboard head.
  task automatic wait_issue(input string tag, input int budget);
    bit found;
    logic [PKT_W-1:0] e;
    found = 1'b0;
    for (int k = 0; k < budget && !found; k++) begin
      if (bus.ctrl_en) found = 1'b1;
      else tick();
    end
    check({tag, "_issue"}, 32'(found), 32'd1);
    if (found) begin
      issue_cyc_prev = issue_cyc;
      issue_cyc = cyc;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      check({tag, "_pkt"}, 32'(out_pkt()), 32'(e));
    end
  endtask

  // Normal sender handshake from the ISSUE cycle: drop ready, raise it again.
  task automatic finish_xfer(input string tag, input int idx);
    bus.inter_ready = 1'b0;
    tick();
    check({tag, "_single_strobe"}, 32'(bus.ctrl_en), 32'd0);
    tick();
    bus.inter_ready = 1'b1;
    tick();
    check({tag, "_done"}, 32'(bus.req_done), 32'(1 << idx));
  endtask

  logic [PKT_W-1:0] pa, pb;

  initial begin
    bus.req_en = '0;
    bus.req_pkt = '0;
    bus.inter_ready = 1'b0;

    // ---- reset state ----
    do_reset();
    check("rst_ctrl_en", 32'(bus.ctrl_en), 32'd0);
    check("rst_fields", 32'(out_pkt()), 32'd0);
    check("rst_pending", 32'(bus.req_pending), 32'd0);
    check("rst_done", 32'(bus.req_done), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));

    // ---- single request: msg_type=5, card=17 on requester 1 ----
    bus.inter_ready = 1'b1;
    pa = make_pkt(1'b0, 4'd5, 6'd17, 3'd2, 5'd9, 3'd4);
    send(1, pa);
    tick();
    clear_req();
    check("single_pending", 32'(bus.req_pending), 32'b0010);
    check("single_no_early_en", 32'(bus.ctrl_en), 32'd0);
    tick();
    check("single_latency", 32'(bus.ctrl_en), 32'd1);
    check("single_msg_type", 32'(bus.ctrl_msg_type), 32'd5);
    check("single_card", 32'(bus.ctrl_card), 32'd17);
    exp_q.push_back(pa);
    wait_issue("single", 1);
    finish_xfer("single", 1);
    check("single_pending_clr", 32'(bus.req_pending), 32'd0);
    tick();
    check("single_done_1cyc", 32'(bus.req_done), 32'd0);
    check("single_idle_fields", 32'(out_pkt()), 32'd0);

    // ---- simultaneous requests after priming requester 0 ----
    do_reset();
    bus.inter_ready = 1'b1;
    pa = make_pkt(1'b1, 4'd1, 6'd1, 3'd1, 5'd1, 3'd1);
    send(0, pa);
    tick();
    clear_req();
    exp_q.push_back(pa);
    wait_issue("prime", 4);
    finish_xfer("prime", 0);
    send(0, make_pkt(1'b0, 4'd2, 6'd10, 3'd0, 5'd0, 3'd0));
    send(1, make_pkt(1'b0, 4'd3, 6'd11, 3'd0, 5'd0, 3'd0));
    send(3, make_pkt(1'b0, 4'd4, 6'd13, 3'd0, 5'd0, 3'd0));
    tick();
    clear_req();
    check("multi_pending", 32'(bus.req_pending), 32'b1011);
`ifdef ARB_ROUND_ROBIN_EN
    exp_q.push_back(make_pkt(1'b0, 4'd3, 6'd11, 3'd0, 5'd0, 3'd0));
    exp_q.push_back(make_pkt(1'b0, 4'd4, 6'd13, 3'd0, 5'd0, 3'd0));
    exp_q.push_back(make_pkt(1'b0, 4'd2, 6'd10, 3'd0, 5'd0, 3'd0));
    wait_issue("multi_a", 4); finish_xfer("multi_a", 1);
    wait_issue("multi_b", 4); finish_xfer("multi_b", 3);
    wait_issue("multi_c", 4); finish_xfer("multi_c", 0);
`else
    exp_q.push_back(make_pkt(1'b0, 4'd2, 6'd10, 3'd0, 5'd0, 3'd0));
    exp_q.push_back(make_pkt(1'b0, 4'd3, 6'd11, 3'd0, 5'd0, 3'd0));
    exp_q.push_back(make_pkt(1'b0, 4'd4, 6'd13, 3'd0, 5'd0, 3'd0));
    wait_issue("multi_a", 4); finish_xfer("multi_a", 0);
    wait_issue("multi_b", 4); finish_xfer("multi_b", 1);
    wait_issue("multi_c", 4); finish_xfer("multi_c", 3);
`endif
    check("multi_pending_clr", 32'(bus.req_pending), 32'd0);

    // ---- overflow: second request while slot 2 waits on ready=0 ----
    do_reset();
    bus.inter_ready = 1'b0;
    pa = make_pkt(1'b0, 4'd7, 6'd33, 3'd5, 5'd20, 3'd6);
    pb = make_pkt(1'b1, 4'd9, 6'd44, 3'd3, 5'd30, 3'd2);
    send(2, pa);
    tick();
    check("ovf_first_clean", 32'(bus.overflow), 32'd0);
    send(2, pb);
    tick();
    clear_req();
    check("ovf_set", 32'(bus.overflow), 32'd1);
    check("ovf_pending", 32'(bus.req_pending), 32'b0100);
    check("ovf_no_issue", 32'(bus.ctrl_en), 32'd0);
    tick();
    tick();
    bus.inter_ready = 1'b1;
    exp_q.push_back(pa);
    wait_issue("ovf", 4);
    finish_xfer("ovf", 2);
    check("ovf_sticky", 32'(bus.overflow), 32'd1);
    check("ovf_dropped", 32'(bus.req_pending), 32'd0);
    do_reset();
    check("ovf_rst_clear", 32'(bus.overflow), 32'd0);

    // ---- timeout: sender never drops ready ----
    bus.inter_ready = 1'b1;
    pa = make_pkt(1'b0, 4'd12, 6'd5, 3'd7, 5'd3, 3'd3);
    send(3, pa);
    tick();
    clear_req();
    exp_q.push_back(pa);
    wait_issue("to", 4);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("to_no_reissue", 32'(bus.ctrl_en), 32'd0);
      check("to_no_early_done", 32'(bus.req_done), 32'd0);
      if (k == 4) check("to_still_busy", 32'(bus.dbg_state), 32'(ST_WAIT_BUSY));
      if (k == 5) check("to_left_busy", 32'(bus.dbg_state), 32'(ST_WAIT_DONE));
    end
    tick();
    check("to_done", 32'(bus.req_done), 32'b1000);
    check("to_pending_clr", 32'(bus.req_pending), 32'd0);
    tick();
    tick();
    check("to_no_second_en", 32'(bus.ctrl_en), 32'd0);

    // ---- reset mid-transfer via interboard_rst in WAIT_DONE ----
    do_reset();
    bus.inter_ready = 1'b1;
    pa = make_pkt(1'b1, 4'd6, 6'd60, 3'd4, 5'd31, 3'd7);
    send(0, pa);
    tick();
    clear_req();
    exp_q.push_back(pa);
    wait_issue("mid", 4);
    bus.inter_ready = 1'b0;
    tick();
    tick();
    check("mid_in_wait_done", 32'(bus.dbg_state), 32'(ST_WAIT_DONE));
    interboard_rst = 1'b1;
    bus.inter_ready = 1'b1;
    tick();
    interboard_rst = 1'b0;
    check("mid_fields_zero", 32'(out_pkt()), 32'd0);
    check("mid_en_zero", 32'(bus.ctrl_en), 32'd0);
    check("mid_pending_zero", 32'(bus.req_pending), 32'd0);
    check("mid_no_done", 32'(bus.req_done), 32'd0);
    check("mid_state_idle", 32'(bus.dbg_state), 32'(ST_IDLE));
    tick();
    check("mid_no_done_late", 32'(bus.req_done), 32'd0);

    // ---- back-to-back: re-request requester 0 in its req_done cycle ----
    do_reset();
    bus.inter_ready = 1'b1;
    pa = make_pkt(1'b0, 4'd10, 6'd21, 3'd1, 5'd2, 3'd5);
    pb = make_pkt(1'b1, 4'd11, 6'd22, 3'd6, 5'd17, 3'd1);
    send(0, pa);
    tick();
    clear_req();
    exp_q.push_back(pa);
    wait_issue("b2b_first", 4);
    finish_xfer("b2b_first", 0);
    send(0, pb);
    tick();
    clear_req();
    check("b2b_accepted", 32'(bus.req_pending), 32'b0001);
    check("b2b_no_ovf", 32'(bus.overflow), 32'd0);
    exp_q.push_back(pb);
    wait_issue("b2b_second", 4);
    check("b2b_spacing_min", 32'(issue_cyc - issue_cyc_prev >= 4), 32'd1);
    check("b2b_spacing", 32'(issue_cyc - issue_cyc_prev), 32'd5);
    finish_xfer("b2b_second", 0);
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
